// File: rtl/sti_quad_if.sv
// Handshake bundle between an upstream share producer and the sti_quad_layer TI share layer.
// The block uses the slave modport; the driving environment uses the master modport.
interface sti_quad_if #(
  parameter int W    = 16,
  parameter int NOUT = 8
) ();
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [NOUT-1:0] rnd;
  logic            out_valid;
  logic            out_ready;
  logic [NOUT-1:0] out_data;
  logic            busy;

  modport master (
    output in_valid, in_data, rnd, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rnd, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sti_quad_layer.sv
// Registered threshold-implementation share layer: each output bit is a quadratic ANF of the
// input shares, masked with fresh randomness. Parallel (all bits per cycle) or serial (one bit per cycle).
module sti_quad_layer #(
  parameter int                     W      = 16,
  parameter int                     NOUT   = 8,
  parameter logic [NOUT*W-1:0]      LIN    = '0,
  parameter logic [NOUT*W*W-1:0]    QUAD   = '0,
  parameter logic [NOUT-1:0]        CONST  = '0,
  parameter bit                     SERIAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  sti_quad_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [NOUT-1:0] out_data_r;
  logic            out_valid_r;
  logic            in_ready_s;
  logic            busy_s;

  // Coordinate function o of x; QUAD bits with i >= j are never visited.
  function automatic logic eval_bit(input logic [W-1:0] x, input int o);
    logic acc;
    acc = CONST[o];
    for (int i = 0; i < W; i++) begin
      acc = acc ^ (LIN[o*W+i] & x[i]);
      for (int j = i + 1; j < W; j++) begin
        acc = acc ^ (QUAD[o*W*W+i*W+j] & x[i] & x[j]);
      end
    end
    return acc;
  endfunction

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_s;

  if (SERIAL) begin : g_serial
    localparam int KW = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NOUT - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t          state_r;
    state_t          state_s;
    logic [KW-1:0]   k_r;
    logic [W-1:0]    x_hold_r;
    logic [NOUT-1:0] r_hold_r;

    // Next-state and input-ready decode.
    always_comb begin
      state_s    = state_r;
      in_ready_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          in_ready_s = rst_n;
          if (bus.in_valid && rst_n) begin
            state_s = ST_EVAL;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EVAL: begin
          if (k_r == K_LAST) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_EVAL;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    // State register plus the shared evaluator datapath; only x_hold/r_hold feed the result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r     <= ST_IDLE;
        k_r         <= '0;
        x_hold_r    <= '0;
        r_hold_r    <= '0;
        out_valid_r <= 1'b0;
        out_data_r  <= '0;
      end else begin
        state_r <= state_s;
        case (state_r)
          ST_IDLE: begin
            if (bus.in_valid) begin
              x_hold_r <= bus.in_data;
              r_hold_r <= bus.rnd;
              k_r      <= '0;
            end
          end
          ST_EVAL: begin
            out_data_r[k_r] <= eval_bit(x_hold_r, int'(k_r)) ^ r_hold_r[k_r];
            if (k_r == K_LAST) begin
              k_r         <= '0;
              out_valid_r <= 1'b1;
            end else begin
              k_r <= k_r + K_ONE;
            end
          end
          ST_DONE: begin
            if (bus.out_ready) begin
              out_valid_r <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    assign busy_s = (state_r != ST_IDLE);

  end else begin : g_parallel
    logic [NOUT-1:0] f_s;

    // All coordinates evaluated at once from the live input.
    always_comb begin
      f_s = '0;
      for (int o = 0; o < NOUT; o++) begin
        f_s[o] = eval_bit(bus.in_data, o);
      end
    end

    assign in_ready_s = rst_n & (~out_valid_r | bus.out_ready);

    // Single output stage; a drain and a load in the same cycle keep out_valid high.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_r <= 1'b0;
        out_data_r  <= '0;
      end else if (bus.in_valid && in_ready_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= f_s ^ bus.rnd;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end

    assign busy_s = out_valid_r;
  end

endmodule

// File: doc/sti_quad_layer.md
# sti_quad_layer

Parametrised, registered threshold-implementation (TI) share layer for lightweight S-boxes. Each of NOUT output bits is a quadratic ANF of W input share bits, with coefficients given as parameters. The output is refreshed with fresh randomness and registered, which provides the glitch barrier required between TI rounds. It replaces the per-bit combinational share functions in multi-round S-box pipelines, and offers a one-cycle parallel mode and a low-area serial mode (one shared evaluator, one output bit per cycle).

## Interface
Parameters:
- W, 16, input share-vector width.
- NOUT, 8, number of output coordinate bits.
- LIN, 0, NOUT*W bits; bit o*W+i set means x[i] is a term of output o.
- QUAD, 0, NOUT*W*W bits; bit o*W*W+i*W+j with i<j set means x[i]&x[j] is a term of output o. Bits with i>=j are ignored.
- CONST, 0, NOUT bits; constant term per output.
- SERIAL, 0, 0 = parallel (all bits in one cycle), 1 = serial (one bit per cycle).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data/rnd valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  W  input share bits x.
- rnd  in  NOUT  fresh refresh mask, sampled with in_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NOUT  f(x) ^ rnd, registered.
- busy  out  1  a transfer is in flight (EVAL or out_valid).

## Operation
- f_o(x) = CONST[o] ^ XOR over i of (LIN[o*W+i] & x[i]) ^ XOR over i<j of (QUAD[o*W*W+i*W+j] & x[i] & x[j]).
- out_data[o] = f_o(in_data) ^ rnd[o]. The integrator makes the masks sum to zero across share instances.
- Only registered values leave the block. There is no combinational path from in_data or rnd to out_data.
- Parallel mode (SERIAL=0):
  - Single output register stage.
  - in_ready = rst_n & (!out_valid | out_ready).
  - A handshake (in_valid & in_ready) loads out_data and sets out_valid.
  - If out_valid & out_ready occurs without a new input, out_valid clears.
  - A simultaneous drain and load keeps out_valid high with the new data.
- Serial mode (SERIAL=1): FSM with states IDLE, EVAL, DONE, and counter k of width clog2(NOUT).
  - IDLE: in_ready = rst_n. On handshake, capture in_data into x_hold and rnd into r_hold, clear k, go to EVAL.
  - EVAL: compute bit k from x_hold only and write out_data[k] = f_k(x_hold) ^ r_hold[k]. Increment k. When k == NOUT-1, go to DONE and set out_valid.
  - DONE: hold out_data. When out_ready, clear out_valid and go to IDLE.
  - in_ready = 0 in EVAL and DONE. in_data and rnd are ignored there.
  - k wraps to 0 on the EVAL to DONE transition.
- busy = out_valid in parallel mode; busy = (state != IDLE) in serial mode.
- Reset (rst_n low at a clock edge), in any state including mid-EVAL:
  - state = IDLE, k = 0, out_valid = 0, out_data = 0, x_hold = 0, r_hold = 0.
  - Any partial result is discarded.
  - in_ready = 0 while rst_n is low.

## Timing
- Parallel: handshake at edge T gives out_valid = 1 and valid out_data after edge T, so latency is 1 cycle. Throughput is 1 per cycle when out_ready = 1.
- Serial: handshake at edge T. Bit k is written at edge T+1+k. out_valid rises after edge T+NOUT.
  - Earliest next acceptance is the cycle after the out_ready handshake, so throughput is 1 per NOUT+2 cycles at most.
- out_data and out_valid hold stable while out_valid & !out_ready.
- Unwritten bits of out_data in EVAL keep their previous values. They are not observable because out_valid = 0.

## Test plan
All scenarios use this configuration: W=4, NOUT=2, CONST=0, LIN=8'b0100_0001 (out0: x0, out1: x2), QUAD bit 1 and bit 27 set (out0: x0x1, out1: x2x3).

- Parallel, in_data=4'b0101, rnd=2'b00 → 2'b11 after 1 cycle. in_data=4'b1111 → 2'b00. in_data=4'b0101, rnd=2'b01 → 2'b10.
- Parallel back-pressure: out_ready=0 for 3 cycles with in_valid held → in_ready=0, out_data held. Release out_ready → drain and load in the same cycle, out_valid stays 1.
- Serial, in_data=4'b0101, rnd=2'b00 → in_ready=0 for EVAL, out_valid high 2 cycles after accept, out_data=2'b11, busy=1 throughout.
- Serial, change in_data during EVAL → result unaffected (uses x_hold).
- Reset mid-EVAL (rst_n low 1 cycle after accept) → out_valid=0, out_data=0, busy=0, in_ready=1 on the first cycle after rst_n rises.
- Random regression: 1000 random in_data/rnd vectors in both modes against the ANF reference model, with random out_ready stalls → all match, no drops or duplicates.
